// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style LCD controllers: FSM states,
// result/argument bit positions and default 50 MHz bus timing.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_EN_HI,
        ST_EN_LO,
        ST_CHECK
    } lcd_state_e;

    localparam int unsigned DATA_LSB    = 0;
    localparam int unsigned TIMEOUT_BIT = 8;
    localparam int unsigned COUNT_LSB   = 16;

    localparam int unsigned RS_BIT   = 0;
    localparam int unsigned POLL_BIT = 1;

    localparam int unsigned DEF_SETUP_CYCLES   = 3;
    localparam int unsigned DEF_EN_HIGH_CYCLES = 25;
    localparam int unsigned DEF_EN_LOW_CYCLES  = 25;
    localparam int unsigned DEF_MAX_POLLS      = 1000;

    function automatic logic [31:0] pack_result(input logic [15:0] count,
                                                input logic        timeout,
                                                input logic [7:0]  data);
        logic [31:0] r;
        r                     = '0;
        r[DATA_LSB +: 8]      = data;
        r[TIMEOUT_BIT]        = timeout;
        r[COUNT_LSB +: 16]    = count;
        return r;
    endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Enable-gated phase counter: clears on request, flags the last cycle of a
// phase whose length is supplied at run time.
module lcd_phase_timer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] limit_i,
    output logic             tc_o
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) count_d = '0;
        else       count_d = count_q + ONE;
    end

    always_ff @(posedge clock) begin
        if (reset)     count_q <= '0;
        else if (en_i) count_q <= count_d;
    end

    assign tc_o = (count_q == (limit_i - ONE));

endmodule

// File: rtl/lcd_reader.sv
// LCD read controller behind a Nios II custom-instruction handshake: single
// BF/data reads or busy-flag polling with a bounded number of reads.
module lcd_reader
    import lcd_pkg::*;
#(
    parameter int unsigned SETUP_CYCLES   = DEF_SETUP_CYCLES,
    parameter int unsigned EN_HIGH_CYCLES = DEF_EN_HIGH_CYCLES,
    parameter int unsigned EN_LOW_CYCLES  = DEF_EN_LOW_CYCLES,
    parameter int unsigned MAX_POLLS      = DEF_MAX_POLLS
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clock_en,
    input  logic        start,
    input  logic [31:0] data_a,
    input  logic [31:0] data_b,
    output logic [31:0] result,
    output logic        done,
    output logic        busy,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic        lcd_en,
    input  logic [7:0]  lcd_data_in
);

    localparam logic [15:0] SETUP_L = 16'(SETUP_CYCLES);
    localparam logic [15:0] HIGH_L  = 16'(EN_HIGH_CYCLES);
    localparam logic [15:0] LOW_L   = 16'(EN_LOW_CYCLES);
    localparam logic [15:0] POLLS_L = 16'(MAX_POLLS);

    lcd_state_e  state_q, state_d;
    logic        rs_q, rs_d, rw_q, rw_d, en_q, en_d;
    logic        poll_q, poll_d, done_q, done_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  data_q, data_d;
    logic [31:0] result_q, result_d;
    logic [15:0] phase_limit;
    logic        tmr_clr, tmr_tc, timeout;

    logic unused_inputs;
    assign unused_inputs = ^{data_b, data_a[31:2]};

    lcd_phase_timer #(.WIDTH(16)) u_timer (
        .clock   (clock),
        .reset   (reset),
        .en_i    (clock_en),
        .clr_i   (tmr_clr),
        .limit_i (phase_limit),
        .tc_o    (tmr_tc)
    );

    assign timeout = poll_q & data_q[7] & (cnt_q == POLLS_L);

    always_comb begin
        state_d     = state_q;
        rs_d        = rs_q;
        rw_d        = rw_q;
        en_d        = en_q;
        poll_d      = poll_q;
        done_d      = done_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        result_d    = result_q;
        phase_limit = SETUP_L;
        tmr_clr     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                done_d  = 1'b0;
                tmr_clr = 1'b1;
                if (start) begin
                    state_d = ST_SETUP;
                    rs_d    = data_a[RS_BIT] & ~data_a[POLL_BIT];
                    rw_d    = 1'b1;
                    en_d    = 1'b0;
                    poll_d  = data_a[POLL_BIT];
                    cnt_d   = '0;
                end
            end
            ST_SETUP: begin
                phase_limit = SETUP_L;
                if (tmr_tc) begin
                    state_d = ST_EN_HI;
                    en_d    = 1'b1;
                    tmr_clr = 1'b1;
                end
            end
            ST_EN_HI: begin
                phase_limit = HIGH_L;
                if (tmr_tc) begin
                    state_d = ST_EN_LO;
                    en_d    = 1'b0;
                    data_d  = lcd_data_in;
                    cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
                    tmr_clr = 1'b1;
                end
            end
            ST_EN_LO: begin
                phase_limit = LOW_L;
                if (tmr_tc) begin
                    state_d = ST_CHECK;
                    tmr_clr = 1'b1;
                end
            end
            ST_CHECK: begin
                tmr_clr = 1'b1;
                // keep polling while the panel still reports busy and budget remains
                if (poll_q && data_q[7] && (cnt_q < POLLS_L)) begin
                    state_d = ST_SETUP;
                end else begin
                    state_d  = ST_IDLE;
                    result_d = pack_result(cnt_q, timeout, data_q);
                    done_d   = 1'b1;
                    rw_d     = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            rs_q     <= 1'b0;
            rw_q     <= 1'b0;
            en_q     <= 1'b0;
            poll_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            data_q   <= '0;
            result_q <= '0;
        end else if (clock_en) begin
            state_q  <= state_d;
            rs_q     <= rs_d;
            rw_q     <= rw_d;
            en_q     <= en_d;
            poll_q   <= poll_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;
    assign done   = done_q;
    assign busy   = (state_q != ST_IDLE);
    assign lcd_rs = rs_q;
    assign lcd_rw = rw_q;
    assign lcd_en = en_q;

    a_params_legal: assert property (@(posedge clock)
        (SETUP_CYCLES != 0) && (EN_HIGH_CYCLES != 0) && (EN_LOW_CYCLES != 0) &&
        (MAX_POLLS != 0) && (MAX_POLLS <= 65535));

endmodule
